// File: rtl/uart_tx_if.sv
// Bus-side connection of the UART transmitter: FIFO push port, FIFO status and
// the per-frame line configuration sampled when a byte is popped.
interface uart_tx_if;
  logic       tx_queue_we;
  logic [7:0] tx_queue_din;
  logic       parity_en;
  logic       parity_type;
  logic       stop_bits;
  logic       tx_queue_full;
  logic       tx_queue_empty;

  modport master (
    output tx_queue_we, tx_queue_din, parity_en, parity_type, stop_bits,
    input  tx_queue_full, tx_queue_empty
  );

  modport slave (
    input  tx_queue_we, tx_queue_din, parity_en, parity_type, stop_bits,
    output tx_queue_full, tx_queue_empty
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding a start/data/parity/stop frame shifter,
// timed by a 16x oversampling baud tick.
module uart_tx #(
  parameter int unsigned TX_QUEUE_SIZE = 16
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      baud_tick,
  uart_tx_if.slave  bus,
  output logic      tx,
  output logic      tx_busy
);

  localparam int unsigned PtrW = $clog2(TX_QUEUE_SIZE);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e            state_q, state_d;
  logic [3:0]        tick_cnt_q, tick_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic              cfg_pen_q, cfg_pen_d;
  logic              cfg_pt_q, cfg_pt_d;
  logic              cfg_sb_q, cfg_sb_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;

  logic [7:0]        mem_q [TX_QUEUE_SIZE];
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;

  logic              push;
  logic              pop;
  logic              start_frame;
  logic              period_end;

  // Full flag is the pre-edge state, so a push while full is dropped even if a pop coincides.
  assign push = bus.tx_queue_we & ~full_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CntW'(TX_QUEUE_SIZE));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.tx_queue_din;
  end

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    cfg_pen_d   = cfg_pen_q;
    cfg_pt_d    = cfg_pt_q;
    cfg_sb_d    = cfg_sb_q;
    pop         = 1'b0;
    start_frame = 1'b0;
    period_end  = baud_tick && (tick_cnt_q == 4'd15);

    if (baud_tick && (state_q != StIdle)) tick_cnt_d = tick_cnt_q + 4'd1;

    unique case (state_q)
      StIdle: begin
        if (baud_tick && !empty_q) start_frame = 1'b1;
      end
      StStart: begin
        if (period_end) begin
          state_d   = StData;
          bit_cnt_d = 3'd0;
        end
      end
      StData: begin
        if (period_end) begin
          shift_d   = shift_q >> 1;
          par_d     = par_q ^ shift_q[0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d    = cfg_pen_q ? StParity : StStop;
            stop_cnt_d = 1'b0;
          end
        end
      end
      StParity: begin
        if (period_end) begin
          state_d    = StStop;
          stop_cnt_d = 1'b0;
        end
      end
      StStop: begin
        if (period_end) begin
          if (stop_cnt_q == cfg_sb_q) begin
            // Chain straight into the next frame when data is waiting.
            if (!empty_q) start_frame = 1'b1;
            else          state_d     = StIdle;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_frame) begin
      pop        = 1'b1;
      shift_d    = mem_q[rd_ptr_q];
      par_d      = 1'b0;
      cfg_pen_d  = bus.parity_en;
      cfg_pt_d   = bus.parity_type;
      cfg_sb_d   = bus.stop_bits;
      tick_cnt_d = 4'd0;
      state_d    = StStart;
    end

    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = par_d ^ cfg_pt_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      tick_cnt_q <= 4'd0;
      bit_cnt_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      shift_q    <= 8'd0;
      par_q      <= 1'b0;
      cfg_pen_q  <= 1'b0;
      cfg_pt_q   <= 1'b0;
      cfg_sb_q   <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      cfg_pen_q  <= cfg_pen_d;
      cfg_pt_q   <= cfg_pt_d;
      cfg_sb_q   <= cfg_sb_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
    end
  end

  assign tx                 = tx_q;
  assign tx_busy            = busy_q;
  assign bus.tx_queue_full  = full_q;
  assign bus.tx_queue_empty = empty_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: expected line waveforms are built as per-frame bit lists
// and compared against tx sampled on every falling clock edge.
module tb_uart_tx;

  localparam int unsigned Depth = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic baud_tick = 1'b0;
  logic tick_en = 1'b0;
  logic tx;
  logic tx_busy;

  int vectors = 0;
  int miscompares = 0;

  bit exp_q[$];

  uart_tx_if bus();

  uart_tx #(.TX_QUEUE_SIZE(Depth)) dut (
    .clk       (clk),
    .reset     (reset),
    .baud_tick (baud_tick),
    .bus       (bus),
    .tx        (tx),
    .tx_busy   (tx_busy)
  );

  initial forever #5 clk = ~clk;

  // baud_tick every 4 clk while enabled
  initial begin
    int div;
    div = 0;
    forever begin
      @(negedge clk);
      if (tick_en) begin
        baud_tick = (div == 3);
        div = (div + 1) % 4;
      end else begin
        baud_tick = 1'b0;
        div = 0;
      end
    end
  end

  task automatic model_frame(input logic [7:0] b, input logic pen, input logic pt,
                             input logic sb);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    if (pen) exp_q.push_back((^b) ^ pt);
    exp_q.push_back(1'b1);
    if (sb) exp_q.push_back(1'b1);
  endtask

  task automatic set_cfg(input logic pen, input logic pt, input logic sb);
    bus.parity_en   = pen;
    bus.parity_type = pt;
    bus.stop_bits   = sb;
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    bus.tx_queue_we  = 1'b1;
    bus.tx_queue_din = b;
    @(negedge clk);
    bus.tx_queue_we  = 1'b0;
  endtask

  // Each expected bit must hold for exactly 64 clk with tx_busy high, then the line idles.
  task automatic check_stream(input string name);
    int   wait_cnt;
    int   n;
    int   glitch;
    logic e;
    logic mid;
    wait_cnt = 0;
    @(negedge clk);
    while (tx !== 1'b0 && wait_cnt < 3000) begin
      @(negedge clk);
      wait_cnt++;
    end
    vectors++;
    if (tx !== 1'b0) begin
      miscompares++;
      $display("FAIL %s start_timeout: tx=%b required 0", name, tx);
      exp_q.delete();
      return;
    end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q[i];
      glitch = 0;
      mid = 1'bx;
      for (int c = 0; c < 64; c++) begin
        if (i != 0 || c != 0) @(negedge clk);
        if (tx !== e || tx_busy !== 1'b1) glitch++;
        if (c == 32) mid = tx;
      end
      vectors++;
      if (mid !== e) begin
        miscompares++;
        $display("FAIL %s bit%0d: tx=%b required %b", name, i, mid, e);
      end
      vectors++;
      if (glitch !== 0) begin
        miscompares++;
        $display("FAIL %s bit%0d_hold: bad_samples=%0d required 0", name, i, glitch);
      end
    end
    @(negedge clk);
    vectors++;
    if (tx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s end_busy: tx_busy=%b required 0", name, tx_busy);
    end
    vectors++;
    if (tx !== 1'b1) begin
      miscompares++;
      $display("FAIL %s end_tx: tx=%b required 1", name, tx);
    end
    vectors++;
    if (bus.tx_queue_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL %s end_empty: empty=%b required 1", name, bus.tx_queue_empty);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    int lows;
    reset = 1'b0;
    tick_en = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: tx=%b required 1", tx); end
    vectors++;
    if (tx_busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy: tx_busy=%b required 0", tx_busy);
    end
    vectors++;
    if (bus.tx_queue_empty !== 1'b1) begin
      miscompares++; $display("FAIL reset_empty: empty=%b required 1", bus.tx_queue_empty);
    end
    vectors++;
    if (bus.tx_queue_full !== 1'b0) begin
      miscompares++; $display("FAIL reset_full: full=%b required 0", bus.tx_queue_full);
    end
    reset = 1'b1;
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) lows++;
    end
    vectors++;
    if (lows !== 0) begin
      miscompares++; $display("FAIL reset_idle: active_samples=%0d required 0", lows);
    end
  endtask

  task automatic test_basic();
    tick_en = 1'b0;
    set_cfg(1'b0, 1'b0, 1'b0);
    push_byte(8'hA5);
    @(negedge clk);
    vectors++;
    if (bus.tx_queue_empty !== 1'b0) begin
      miscompares++; $display("FAIL basic_queued: empty=%b required 0", bus.tx_queue_empty);
    end
    model_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    tick_en = 1'b1;
    check_stream("basic_8n1");
  endtask

  task automatic test_parity();
    tick_en = 1'b0;
    set_cfg(1'b1, 1'b1, 1'b1);
    push_byte(8'h03);
    model_frame(8'h03, 1'b1, 1'b1, 1'b1);
    tick_en = 1'b1;
    check_stream("parity_odd_2stop");
    tick_en = 1'b0;
    set_cfg(1'b1, 1'b0, 1'b1);
    push_byte(8'h03);
    model_frame(8'h03, 1'b1, 1'b0, 1'b1);
    tick_en = 1'b1;
    check_stream("parity_even_2stop");
  endtask

  task automatic test_overflow();
    tick_en = 1'b0;
    set_cfg(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) begin
      push_byte(8'(i));
      if (i == 14) begin
        vectors++;
        if (bus.tx_queue_full !== 1'b0) begin
          miscompares++; $display("FAIL full_at15: full=%b required 0", bus.tx_queue_full);
        end
      end
      if (i == 15) begin
        vectors++;
        if (bus.tx_queue_full !== 1'b1) begin
          miscompares++; $display("FAIL full_at16: full=%b required 1", bus.tx_queue_full);
        end
      end
    end
    vectors++;
    if (bus.tx_queue_full !== 1'b1) begin
      miscompares++; $display("FAIL full_after17: full=%b required 1", bus.tx_queue_full);
    end
    for (int i = 0; i < 16; i++) model_frame(8'(i), 1'b0, 1'b0, 1'b0);
    tick_en = 1'b1;
    check_stream("overflow_drain");
  endtask

  task automatic test_mid_reset();
    int wait_cnt;
    int lows;
    tick_en = 1'b0;
    set_cfg(1'b0, 1'b0, 1'b0);
    push_byte(8'hFF);
    push_byte(8'h00);
    tick_en = 1'b1;
    wait_cnt = 0;
    @(negedge clk);
    while (tx !== 1'b0 && wait_cnt < 3000) begin
      @(negedge clk);
      wait_cnt++;
    end
    vectors++;
    if (tx !== 1'b0) begin
      miscompares++; $display("FAIL midreset_start: tx=%b required 0", tx);
    end
    repeat (64 * 4 + 20) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (tx !== 1'b1) begin miscompares++; $display("FAIL midreset_tx: tx=%b required 1", tx); end
    vectors++;
    if (tx_busy !== 1'b0) begin
      miscompares++; $display("FAIL midreset_busy: tx_busy=%b required 0", tx_busy);
    end
    vectors++;
    if (bus.tx_queue_empty !== 1'b1) begin
      miscompares++; $display("FAIL midreset_empty: empty=%b required 1", bus.tx_queue_empty);
    end
    @(negedge clk);
    reset = 1'b1;
    lows = 0;
    repeat (1500) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) lows++;
    end
    vectors++;
    if (lows !== 0) begin
      miscompares++; $display("FAIL midreset_silent: active_samples=%0d required 0", lows);
    end
  endtask

  task automatic test_cfg_change();
    logic [7:0] a;
    logic [7:0] b;
    a = 8'($urandom);
    b = 8'($urandom);
    tick_en = 1'b0;
    set_cfg(1'b0, 1'b0, 1'b0);
    push_byte(a);
    push_byte(b);
    model_frame(a, 1'b0, 1'b0, 1'b0);
    model_frame(b, 1'b1, 1'b0, 1'b0);
    tick_en = 1'b1;
    fork
      check_stream("cfg_change");
      begin
        repeat (300) @(negedge clk);
        bus.parity_en = 1'b1;
      end
    join
    bus.parity_en = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic pen, pt, sb;
    for (int k = 0; k < 6; k++) begin
      b   = 8'($urandom);
      pen = 1'($urandom_range(0, 1));
      pt  = 1'($urandom_range(0, 1));
      sb  = 1'($urandom_range(0, 1));
      tick_en = 1'b0;
      set_cfg(pen, pt, sb);
      push_byte(b);
      model_frame(b, pen, pt, sb);
      tick_en = 1'b1;
      check_stream("random_single");
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    logic pen, pt, sb;
    pen = 1'($urandom_range(0, 1));
    pt  = 1'($urandom_range(0, 1));
    sb  = 1'($urandom_range(0, 1));
    tick_en = 1'b0;
    set_cfg(pen, pt, sb);
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom);
      push_byte(b);
      model_frame(b, pen, pt, sb);
    end
    tick_en = 1'b1;
    check_stream("back_to_back");
  endtask

  initial begin
    bus.tx_queue_we  = 1'b0;
    bus.tx_queue_din = 8'h00;
    set_cfg(1'b0, 1'b0, 1'b0);
    test_reset();
    test_basic();
    test_parity();
    test_overflow();
    test_mid_reset();
    test_cfg_change();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter: buffers bytes written by the bus-side peripheral logic in an internal FIFO and shifts each one out on `tx` as a start bit, 8 data bits (LSB first), an optional parity bit and 1 or 2 stop bits. Bit timing comes from an external 16x-oversampling `baud_tick`, the same tick the receive side uses. The block sits beside the UART receive path inside the UART peripheral and drives the TX pin directly.

## Interface

Parameters:
- `TX_QUEUE_SIZE`, 16, FIFO depth in bytes; must be a power of two and at least 2.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `baud_tick`  in  1  one-cycle pulse at 16x the baud rate.
- `tx_queue_we`  in  1  push `tx_queue_din` into the FIFO.
- `tx_queue_din`  in  8  byte to transmit.
- `parity_en`  in  1  1 = append a parity bit.
- `parity_type`  in  1  0 = even parity, 1 = odd parity.
- `stop_bits`  in  1  0 = one stop bit, 1 = two stop bits.
- `tx_queue_full`  out  1  FIFO holds `TX_QUEUE_SIZE` entries.
- `tx_queue_empty`  out  1  FIFO holds 0 entries.
- `tx_busy`  out  1  a frame is in progress (state other than IDLE).
- `tx`  out  1  serial line, registered, idle high.

## Operation

- **FIFO**
  - Circular buffer with read pointer, write pointer and an occupancy count of width clog2(`TX_QUEUE_SIZE`)+1.
  - A push while `tx_queue_full`=1 is ignored; contents and pointers are unchanged.
  - A push and a pop in the same cycle are both performed and occupancy does not change. A push when full is still ignored in that cycle, because `tx_queue_full` reflects the state before the edge.
- **State machine**: IDLE, START, DATA, PARITY, STOP.
  - Tick counter is 4 bits; bit counter is 3 bits; stop counter is 1 bit.
  - A bit period ends on the `baud_tick` where the tick counter equals 15; the counter then wraps to 0.
- **IDLE**
  - `tx`=1.
  - On a `baud_tick` with the FIFO non-empty: pop the head byte into an 8-bit shift register, latch `parity_en`, `parity_type` and `stop_bits`, clear the tick counter and go to START.
  - Configuration inputs are sampled only at this point; changing them mid-frame has no effect on the current frame.
- **START**
  - `tx`=0 for one bit period, then go to DATA with the bit counter at 0.
- **DATA**
  - `tx` = shift register bit 0.
  - At the end of each period, shift right and fold the transmitted bit into a running parity XOR.
  - After bit counter = 7, go to PARITY if the latched `parity_en`=1, otherwise go to STOP.
- **PARITY**
  - `tx` = XOR of the 8 data bits, XORed with the latched `parity_type`.
  - Lasts one bit period, then go to STOP.
- **STOP**
  - `tx`=1 for 1 bit period, or 2 if the latched `stop_bits`=1.
  - At the end of the final stop period: if the FIFO is non-empty, pop and go directly to START in that same tick (no idle gap, with the new configuration latched). Otherwise go to IDLE.
- **Reset (`reset`=0 at a rising edge), from any state including mid-frame**
  - State returns to IDLE, the FIFO is emptied and all counters and the parity XOR are cleared.
  - Outputs after reset: `tx`=1, `tx_busy`=0, `tx_queue_empty`=1, `tx_queue_full`=0.
- `baud_tick` is ignored while `reset`=0.

## Timing

- `tx` is registered. A state or bit change triggered by the tick at cycle N appears on `tx` at cycle N+1.
- `tx_busy` is registered and rises together with the falling start edge on `tx`.
- `tx_busy` stays high through back-to-back frames. It falls in the cycle after the final stop-bit tick when the FIFO is empty.
- Each bit lasts exactly 16 `baud_tick`s.
- Frame length in ticks is 16 × (10 + `parity_en` + `stop_bits`).
- Latency from a push into an empty FIFO in IDLE to the start bit on `tx`: the first `baud_tick` strictly after the push cycle, plus 1 clk.
- `tx_queue_empty` and `tx_queue_full` are registered. They update in the cycle after the push or pop edge.

## Test plan

- **Reset values**: hold `reset`=0 for 3 clk → `tx`=1, `tx_busy`=0, `tx_queue_empty`=1, `tx_queue_full`=0. Pulse `baud_tick` while in reset → no change.
- **Basic 8N1 frame**: `baud_tick` every 4 clk; push 0xA5 with parity off and 1 stop bit → `tx` shows 0,1,0,1,0,0,1,0,1,1, each bit 64 clk. `tx_busy` falls after 640 clk and `tx_queue_empty` returns to 1.
- **Parity and stop options**:
  - Push 0x03 with `parity_en`=1, `parity_type`=1 (odd), `stop_bits`=1 → parity bit 1, two stop bits, 12 bit periods total.
  - Repeat with even parity → parity bit 0.
- **FIFO full and overflow**: hold `baud_tick` low and push 17 bytes 0x00..0x10 → `tx_queue_full`=1 after the 16th push and the 17th push is ignored. Enable ticks → exactly 0x00..0x0F are transmitted, back-to-back with no idle gap.
- **Mid-frame reset**: push 0xFF, assert `reset`=0 during DATA bit 3 → the cycle after the reset edge shows `tx`=1 and `tx_busy`=0, the FIFO is empty and no further frame follows.
- **Config change mid-frame**: start an 8N1 frame, set `parity_en`=1 during DATA → the current frame has no parity bit. If a second byte is queued, its frame includes the parity bit.
